cg_mem_addr_sequencer: RTL
==========================

// Module: cg_mem_addr_sequencer
// PURPOSE
//  Parametrised successor to the CG solver address control: one FSM plus NUM_CH
//  vector-memory channels (P, R, X, P_v2, ...), each with its own read and write
//  address counter, and a linear A-matrix read counter. All counters wrap
//  exactly at depth = total/NO_OF_UNITS; no address past depth-1 is ever driven.
//  Tracks solver iterations and halts on max_iter or finish_all. Single-cycle
//  advance only; no multi-edge waits.
// PARAMETERS
//  NO_OF_UNITS  8   ALU lanes; power of 2; depth = total >> log2(NO_OF_UNITS)
//  ADDR_W       32  vector-memory address width
//  A_ADDR_W     32  A-matrix address width
//  NUM_CH       4   number of vector-memory channels
//  ITER_W       11  iteration counter width
//  FINISH_HOLD  4   consecutive finish_alu cycles that close one iteration
// PORTS
//  clk          in   1               clock
//  reset        in   1               sync, active-high
//  total        in   32              problem size; sampled on start
//  max_iter     in   ITER_W          iteration limit; sampled on start; 0 = unlimited
//  start        in   1               1-cycle pulse, accepted only in IDLE
//  pre_process  in   1               A-memory streaming enable
//  finish_alu   in   1               end-of-iteration level from ALU
//  finish_all   in   1               convergence; halts immediately
//  rd_adv       in   NUM_CH          per-channel read advance
//  wr_req       in   NUM_CH          per-channel result write request
//  rd_addr      out  NUM_CH*ADDR_W   packed read addresses, ch0 in LSBs
//  wr_addr      out  NUM_CH*ADDR_W   packed write addresses
//  wr_en        out  NUM_CH          = wr_req & {NUM_CH{state==RUN}}, combinational
//  rd_wrap      out  NUM_CH          1-cycle pulse when a read counter wraps
//  a_rd_addr    out  A_ADDR_W        A-matrix read address
//  a_rd_valid   out  1               a_rd_addr meaningful this cycle
//  iteration    out  ITER_W          completed iterations
//  busy         out  1               state != IDLE && state != HALTED
//  halt         out  1               sticky until reset
//  cfg_err      out  1               start seen with depth==0; sticky until reset/next good start
// BEHAVIOUR
//  Reset: every output and counter 0; state IDLE. Reset has priority over all inputs.
//  FSM: IDLE -start&&depth!=0-> RUN. IDLE -start&&depth==0-> IDLE, cfg_err=1.
//   RUN -finish_alu-> DRAIN. DRAIN -finish_alu low before FINISH_HOLD-> RUN.
//   DRAIN on FINISH_HOLD-th consecutive finish_alu cycle: iteration+1;
//   if max_iter!=0 && iteration+1==max_iter -> HALTED, else -> RUN.
//   Any state -finish_all-> HALTED, iteration+1 (only if not already HALTED).
//   HALTED is terminal until reset.
//  Channel counters (RUN only): rd_adv[i] -> rd_addr[i]+1;
//   at depth-1, wrap to 0 and pulse rd_wrap[i] next cycle.
//   wr_req[i] -> wr_addr[i]+1, same wrap rule (no pulse).
//   In DRAIN, and on entry to RUN, all channel counters clear to 0.
//   rd_adv/wr_req in IDLE, DRAIN or HALTED are ignored; wr_en is low there.
//  A counter: pre_process && !halt && state!=IDLE -> a_rd_addr+1
//   (first valid address 0, a_rd_valid=1 from first enable);
//   cleared with channel counters in DRAIN; free-running, no wrap
//   (2^A_ADDR_W must exceed nnz).
//  Simultaneous: finish_all beats finish_alu; finish_alu beats rd_adv/wr_req
//   in the same cycle (advance dropped). start outside IDLE is ignored.
//  Arithmetic: depth is a 32-bit unsigned right shift; compares use equality
//   to depth-1, never >=.
// STRUCTURE
//  cg_pkg: state enum (IDLE, RUN, DRAIN, HALTED), clog2 helper, NO_OF_UNITS default.
//  Sub-module cg_wrap_counter (ADDR_W; inputs clr, adv, depth; outputs addr, wrap),
//   instantiated 2*NUM_CH times via generate. Top holds FSM, A counter, iteration logic.
// TESTING
//  1 total=64, start, rd_adv[0] held 8 cycles -> rd_addr0 0..7 then 0, rd_wrap[0] once.
//  2 total=4 (<8), start -> cfg_err=1, busy=0, state IDLE; later total=64, start -> RUN, cfg_err=0.
//  3 max_iter=3, finish_alu pulses of 4 cycles x3 -> iteration=3, halt=1;
//    a 3-cycle pulse does not count.
//  4 finish_all mid-RUN with rd_adv/wr_req active -> halt next cycle, wr_en=0,
//    counters frozen, iteration+1.
//  5 reset asserted mid-DRAIN with counters nonzero -> all outputs 0 next cycle, IDLE.
//  6 NUM_CH=2 build: independent rd_adv patterns on ch0/ch1 -> addresses
//    diverge correctly; wr_req ignored in DRAIN.

Source files
------------

// File: rtl/cg_mem_addr_sequencer_pkg.sv
// Shared types and helpers for the CG solver address sequencer.
package cg_mem_addr_sequencer_pkg;

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   // Default number of ALU lanes sharing one vector memory word
   localparam int unsigned CG_NO_OF_UNITS = 8;

   // Ceiling log2; returns 0 for inputs of 0 or 1
   function automatic int unsigned cg_clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cg_mem_addr_sequencer_if.sv
// Channel and A-matrix address bus between the ALU side (master) and the
// address sequencer (slave).
interface cg_mem_addr_sequencer_if #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned A_ADDR_W = 32
);
   logic [NUM_CH-1:0]        rd_adv;
   logic [NUM_CH-1:0]        wr_req;
   logic [NUM_CH*ADDR_W-1:0] rd_addr;
   logic [NUM_CH*ADDR_W-1:0] wr_addr;
   logic [NUM_CH-1:0]        wr_en;
   logic [NUM_CH-1:0]        rd_wrap;
   logic [A_ADDR_W-1:0]      a_rd_addr;
   logic                     a_rd_valid;

   modport master (
      output rd_adv, wr_req,
      input  rd_addr, wr_addr, wr_en, rd_wrap, a_rd_addr, a_rd_valid
   );

   modport slave (
      input  rd_adv, wr_req,
      output rd_addr, wr_addr, wr_en, rd_wrap, a_rd_addr, a_rd_valid
   );
endinterface

// File: rtl/cg_mem_addr_sequencer_wrap_counter.sv
// Address counter that wraps to 0 after depth-1 and flags the wrap for one
// cycle, in step with the address returning to 0.
module cg_mem_addr_sequencer_wrap_counter #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              adv,
   input  logic [ADDR_W-1:0] depth,
   output logic [ADDR_W-1:0] addr,
   output logic              wrap
);
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wrap_q, wrap_d;
   logic [ADDR_W-1:0] last;

   // Equality against depth-1 only, so an address past the end is never produced
   assign last = depth - ADDR_W'(1);

   // Next address: clear wins over advance; wrap exactly at the last entry
   always_comb begin
      addr_d = addr_q;
      wrap_d = 1'b0;
      if (clr) begin
         addr_d = '0;
      end else if (adv) begin
         if (addr_q == last) begin
            addr_d = '0;
            wrap_d = 1'b1;
         end else begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end
   end

   // Address and wrap-pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wrap_q <= wrap_d;
      end
   end

   assign addr = addr_q;
   assign wrap = wrap_q;
endmodule

// File: rtl/cg_mem_addr_sequencer.sv
// CG solver address sequencer: control FSM, per-channel read/write address
// counters, linear A-matrix read counter and iteration tracking.
module cg_mem_addr_sequencer
   import cg_mem_addr_sequencer_pkg::*;
#(
   parameter int unsigned NO_OF_UNITS = CG_NO_OF_UNITS,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned A_ADDR_W    = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned ITER_W      = 11,
   parameter int unsigned FINISH_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           total,
   input  logic [ITER_W-1:0]     max_iter,
   input  logic                  start,
   input  logic                  pre_process,
   input  logic                  finish_alu,
   input  logic                  finish_all,
   cg_mem_addr_sequencer_if.slave bus,
   output logic [ITER_W-1:0]     iteration,
   output logic                  busy,
   output logic                  halt,
   output logic                  cfg_err
);
   localparam int unsigned UNIT_SHIFT = cg_clog2(NO_OF_UNITS);
   localparam int unsigned HOLD_RAW   = cg_clog2(FINISH_HOLD + 1);
   localparam int unsigned HOLD_W     = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((FINISH_HOLD > 1) ? (FINISH_HOLD - 1) : 0);

   state_e              state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [ITER_W-1:0]   iter_inc;
   logic                iter_last;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [31:0]         depth_q, depth_d;
   logic [31:0]         depth_in;
   logic [ITER_W-1:0]   max_iter_q, max_iter_d;
   logic                cfg_err_q, cfg_err_d;
   logic [A_ADDR_W-1:0] a_addr_q, a_addr_d;
   logic                a_en;
   logic                clr_ch;
   logic                adv_en;
   logic [ADDR_W-1:0]   depth_addr;

   logic [NUM_CH*ADDR_W-1:0] rd_addr_w;
   logic [NUM_CH*ADDR_W-1:0] wr_addr_w;
   logic [NUM_CH-1:0]        rd_wrap_w;
   logic [NUM_CH-1:0]        wr_wrap_unused;

   // Depth is the per-lane share of the problem: an unsigned shift of total
   assign depth_in   = total >> UNIT_SHIFT;
   assign depth_addr = ADDR_W'(depth_q);
   assign iter_inc   = iter_q + ITER_W'(1);
   assign iter_last  = (max_iter_q != '0) && (iter_inc == max_iter_q);

   // Next state, iteration bookkeeping and counter clear/advance strobes
   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      hold_d     = hold_q;
      depth_d    = depth_q;
      max_iter_d = max_iter_q;
      cfg_err_d  = cfg_err_q;
      clr_ch     = 1'b0;
      adv_en     = 1'b0;
      if (finish_all && (state_q != ST_HALTED)) begin
         // Convergence overrides everything, including a pending finish_alu
         state_d = ST_HALTED;
         iter_d  = iter_inc;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (depth_in == '0) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     cfg_err_d  = 1'b0;
                     depth_d    = depth_in;
                     max_iter_d = max_iter;
                     state_d    = ST_RUN;
                     clr_ch     = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (finish_alu) begin
                  // Advances in this cycle are dropped
                  if (FINISH_HOLD <= 1) begin
                     iter_d  = iter_inc;
                     state_d = iter_last ? ST_HALTED : ST_RUN;
                  end else begin
                     state_d = ST_DRAIN;
                     hold_d  = HOLD_W'(1);
                  end
               end else begin
                  adv_en = 1'b1;
               end
            end
            ST_DRAIN: begin
               clr_ch = 1'b1;
               if (!finish_alu) begin
                  state_d = ST_RUN;
               end else if (hold_q == HOLD_LAST) begin
                  iter_d  = iter_inc;
                  state_d = iter_last ? ST_HALTED : ST_RUN;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_d = ST_HALTED;
            end
         endcase
      end
   end

   // A-matrix stream: free-running while enabled, cleared alongside the channels
   assign a_en = pre_process && !halt && (state_q != ST_IDLE);

   always_comb begin
      a_addr_d = a_addr_q;
      if (clr_ch) begin
         a_addr_d = '0;
      end else if (a_en) begin
         a_addr_d = a_addr_q + A_ADDR_W'(1);
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         iter_q     <= '0;
         hold_q     <= '0;
         depth_q    <= '0;
         max_iter_q <= '0;
         cfg_err_q  <= 1'b0;
         a_addr_q   <= '0;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         hold_q     <= hold_d;
         depth_q    <= depth_d;
         max_iter_q <= max_iter_d;
         cfg_err_q  <= cfg_err_d;
         a_addr_q   <= a_addr_d;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      cg_mem_addr_sequencer_wrap_counter #(.ADDR_W(ADDR_W)) u_rd (
         .clk   (clk),
         .reset (reset),
         .clr   (clr_ch),
         .adv   (adv_en & bus.rd_adv[ch]),
         .depth (depth_addr),
         .addr  (rd_addr_w[ch*ADDR_W +: ADDR_W]),
         .wrap  (rd_wrap_w[ch])
      );
      cg_mem_addr_sequencer_wrap_counter #(.ADDR_W(ADDR_W)) u_wr (
         .clk   (clk),
         .reset (reset),
         .clr   (clr_ch),
         .adv   (adv_en & bus.wr_req[ch]),
         .depth (depth_addr),
         .addr  (wr_addr_w[ch*ADDR_W +: ADDR_W]),
         .wrap  (wr_wrap_unused[ch])
      );
   end

   assign bus.rd_addr    = rd_addr_w;
   assign bus.wr_addr    = wr_addr_w;
   assign bus.rd_wrap    = rd_wrap_w;
   assign bus.wr_en      = bus.wr_req & {NUM_CH{state_q == ST_RUN}};
   assign bus.a_rd_addr  = a_addr_q;
   assign bus.a_rd_valid = a_en;

   assign iteration = iter_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign halt      = (state_q == ST_HALTED);
   assign cfg_err   = cfg_err_q;
endmodule
